// File: rtl/l2_write_buffer_if.sv
// l2_write_buffer_if: upstream beat bus, downstream memory beat bus and hazard lookup of the L2 write buffer
// Signals: WR_TO_L2_* / DATA_TO_L2 / WR_COMPLETE (L1 side), WR_TO_MEM_* / DATA_TO_MEM / WR_ADDR_TO_MEM /
// WR_CONTROL_TO_MEM / WR_COMPLETE_FROM_MEM (L2 memory side), LOOKUP_ADDR / LOOKUP_HIT (read-miss check).
// Modports: slave is the buffer's view, master is the view of whoever drives it.
interface l2_write_buffer_if #(parameter int W = 7);
  logic            WR_TO_L2_VALID;
  logic            WR_TO_L2_READY;
  logic [29:0]     WR_ADDR_TO_L2;
  logic [2**W-1:0] DATA_TO_L2;
  logic            WR_CONTROL_TO_L2;
  logic            WR_COMPLETE;
  logic            WR_TO_MEM_VALID;
  logic            WR_TO_MEM_READY;
  logic [29:0]     WR_ADDR_TO_MEM;
  logic [2**W-1:0] DATA_TO_MEM;
  logic            WR_CONTROL_TO_MEM;
  logic            WR_COMPLETE_FROM_MEM;
  logic [29:0]     LOOKUP_ADDR;
  logic            LOOKUP_HIT;
  modport slave (
    input  WR_TO_L2_VALID, WR_ADDR_TO_L2, DATA_TO_L2, WR_CONTROL_TO_L2,
    input  WR_TO_MEM_READY, WR_COMPLETE_FROM_MEM, LOOKUP_ADDR,
    output WR_TO_L2_READY, WR_COMPLETE, WR_TO_MEM_VALID, WR_ADDR_TO_MEM,
    output DATA_TO_MEM, WR_CONTROL_TO_MEM, LOOKUP_HIT
  );
  modport master (
    output WR_TO_L2_VALID, WR_ADDR_TO_L2, DATA_TO_L2, WR_CONTROL_TO_L2,
    output WR_TO_MEM_READY, WR_COMPLETE_FROM_MEM, LOOKUP_ADDR,
    input  WR_TO_L2_READY, WR_COMPLETE, WR_TO_MEM_VALID, WR_ADDR_TO_MEM,
    input  DATA_TO_MEM, WR_CONTROL_TO_MEM, LOOKUP_HIT
  );
endinterface

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: FIFO of 2^D cache lines between L1 write beats and the L2 memory write port
// Ports: CLK, RST (synchronous, active-high); bus (l2_write_buffer_if.slave) carries the upstream beat
// handshake, the downstream beat handshake with line acknowledge, and the read-miss hazard lookup.
// Define L2_WB_LOOKUP_EN to build the lookup comparators; otherwise LOOKUP_HIT is tied low.
module l2_write_buffer #(
  parameter int W = 7,
  parameter int B = 9,
  parameter int D = 1
) (
  input logic              CLK,
  input logic              RST,
  l2_write_buffer_if.slave bus
);
  localparam int BW = B - W;
  localparam int LINES = 2 ** D;
  localparam logic [D-1:0] ONE_D = 1;
  localparam logic [BW-1:0] ONE_B = 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  state_t state, state_n;
  logic [D:0] fill_ptr, drain_ptr, count;
  logic [BW-1:0] fill_beat, drain_beat, drain_beat_n;
  logic [2**W-1:0] data_mem [LINES*(2**BW)];
  logic ctrl_mem [LINES*(2**BW)];
  logic [29:0] addr_mem [LINES];
  logic up_fire, dn_fire, fill_done, retire, load;
  logic unused_lookup;
  // count never exceeds 2^D, so its top bit alone flags a full buffer
  assign bus.WR_TO_L2_READY = !count[D];
  assign up_fire = bus.WR_TO_L2_VALID && bus.WR_TO_L2_READY;
  assign dn_fire = bus.WR_TO_MEM_VALID && bus.WR_TO_MEM_READY;
  assign fill_done = up_fire && &fill_beat;
  assign retire = state == WAIT_ACK && bus.WR_COMPLETE_FROM_MEM;
  assign load = state == IDLE && count != '0;
  assign drain_beat_n = drain_beat + ONE_B;
  assign unused_lookup = ^bus.LOOKUP_ADDR;
  always_ff @(posedge CLK)
    if (up_fire) begin
      data_mem[{fill_ptr[D-1:0], fill_beat}] <= bus.DATA_TO_L2;
      ctrl_mem[{fill_ptr[D-1:0], fill_beat}] <= bus.WR_CONTROL_TO_L2;
      if (fill_beat == '0) addr_mem[fill_ptr[D-1:0]] <= bus.WR_ADDR_TO_L2;
    end
  always_ff @(posedge CLK)
    if (RST) begin
      fill_ptr        <= '0;
      drain_ptr       <= '0;
      count           <= '0;
      fill_beat       <= '0;
      bus.WR_COMPLETE <= 1'b0;
    end else begin
      if (up_fire) fill_beat <= fill_beat + ONE_B;
      if (fill_done) fill_ptr <= {1'b0, fill_ptr[D-1:0] + ONE_D};
      if (retire) drain_ptr <= {1'b0, drain_ptr[D-1:0] + ONE_D};
      count           <= count + (D+1)'(fill_done) - (D+1)'(retire);
      bus.WR_COMPLETE <= fill_done;
    end
  always_ff @(posedge CLK)
    state <= RST ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = load ? SEND : IDLE;
      SEND:     state_n = dn_fire && &drain_beat ? WAIT_ACK : SEND;
      WAIT_ACK: state_n = retire ? IDLE : WAIT_ACK;
      default:  state_n = IDLE;
    endcase
  end
  always_comb
    bus.WR_TO_MEM_VALID = state == SEND;
  // the next beat is fetched on each accepted beat so the registered outputs stream without bubbles
  always_ff @(posedge CLK)
    if (RST) begin
      drain_beat            <= '0;
      bus.DATA_TO_MEM       <= '0;
      bus.WR_CONTROL_TO_MEM <= 1'b0;
      bus.WR_ADDR_TO_MEM    <= '0;
    end else if (load) begin
      drain_beat            <= '0;
      bus.DATA_TO_MEM       <= data_mem[{drain_ptr[D-1:0], {BW{1'b0}}}];
      bus.WR_CONTROL_TO_MEM <= ctrl_mem[{drain_ptr[D-1:0], {BW{1'b0}}}];
      bus.WR_ADDR_TO_MEM    <= addr_mem[drain_ptr[D-1:0]];
    end else if (dn_fire) begin
      drain_beat            <= drain_beat_n;
      bus.DATA_TO_MEM       <= data_mem[{drain_ptr[D-1:0], drain_beat_n}];
      bus.WR_CONTROL_TO_MEM <= ctrl_mem[{drain_ptr[D-1:0], drain_beat_n}];
    end
`ifdef L2_WB_LOOKUP_EN
  logic [LINES-1:0] slot_hit;
  logic fill_hit;
  // a slot holds a buffered line when its distance ahead of the drain pointer is below count
  for (genvar i = 0; i < LINES; i++) begin : g_cmp
    logic [D-1:0] off;
    assign off = D'(i) - drain_ptr[D-1:0];
    assign slot_hit[i] = {1'b0, off} < count && addr_mem[i][29:B-5] == bus.LOOKUP_ADDR[29:B-5];
  end
  assign fill_hit = fill_beat != '0 && addr_mem[fill_ptr[D-1:0]][29:B-5] == bus.LOOKUP_ADDR[29:B-5];
  assign bus.LOOKUP_HIT = |slot_hit || fill_hit;
`else
  assign bus.LOOKUP_HIT = 1'b0;
`endif
endmodule

// File: tb/tb_l2_write_buffer.sv
// tb_l2_write_buffer: directed checks of the L2 write buffer with W=7, B=9, D=1 (4 beats/line, 2 lines)
module tb_l2_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  l2_write_buffer_if #(.W(7)) bus();
  l2_write_buffer #(.W(7), .B(9), .D(1)) dut (.CLK(clk), .RST(rst), .bus(bus));
`ifdef L2_WB_LOOKUP_EN
  localparam logic EXP_HIT = 1'b1;
`else
  localparam logic EXP_HIT = 1'b0;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int n_complete = 0;
  int n_up = 0;
  logic [127:0] q_data[$];
  logic q_ctrl[$];
  logic [29:0] q_addr[$];
  always @(posedge clk)
    if (!rst) begin
      if (bus.WR_TO_MEM_VALID && bus.WR_TO_MEM_READY) begin
        q_data.push_back(bus.DATA_TO_MEM);
        q_ctrl.push_back(bus.WR_CONTROL_TO_MEM);
        q_addr.push_back(bus.WR_ADDR_TO_MEM);
      end
      if (bus.WR_TO_L2_VALID && bus.WR_TO_L2_READY) n_up++;
      if (bus.WR_COMPLETE) n_complete++;
    end
  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [29:0] a, input logic [127:0] d, input logic c);
    int t = 0;
    bus.WR_TO_L2_VALID = 1'b1;
    bus.WR_ADDR_TO_L2 = a;
    bus.DATA_TO_L2 = d;
    bus.WR_CONTROL_TO_L2 = c;
    while (!bus.WR_TO_L2_READY && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 128'(bus.WR_TO_L2_READY), 128'(1));
    @(negedge clk);
  endtask
  task automatic line(input logic [29:0] a, input logic [127:0] base, input logic [3:0] cp,
                      input int first, input int n);
    for (int k = first; k < first + n; k++) beat(a, base + 128'(k), cp[k]);
    bus.WR_TO_L2_VALID = 1'b0;
  endtask
  task automatic wait_q(input int n);
    int t = 0;
    while (q_data.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_count", 128'(q_data.size() >= n), 128'(1));
  endtask
  task automatic ack();
    bus.WR_COMPLETE_FROM_MEM = 1'b1;
    @(negedge clk);
    bus.WR_COMPLETE_FROM_MEM = 1'b0;
  endtask
  task automatic check_line(input int s, input logic [29:0] a, input logic [127:0] base, input logic [3:0] cp);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("beat%0d_data", s + k), q_data[s+k], base + 128'(k));
      chk($sformatf("beat%0d_ctrl", s + k), 128'(q_ctrl[s+k]), 128'(cp[k]));
      chk($sformatf("beat%0d_addr", s + k), 128'(q_addr[s+k]), 128'(a));
    end
  endtask
  initial begin
    int nc, up0, qs;
    logic pv, pr;
    logic [127:0] pd;
    bus.WR_TO_L2_VALID = 1'b0;
    bus.WR_ADDR_TO_L2 = '0;
    bus.DATA_TO_L2 = '0;
    bus.WR_CONTROL_TO_L2 = 1'b0;
    bus.WR_TO_MEM_READY = 1'b0;
    bus.WR_COMPLETE_FROM_MEM = 1'b0;
    bus.LOOKUP_ADDR = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 128'(bus.WR_TO_L2_READY), 128'(1));
    chk("rst_complete", 128'(bus.WR_COMPLETE), 128'(0));
    chk("rst_mem_valid", 128'(bus.WR_TO_MEM_VALID), 128'(0));
    chk("rst_hit", 128'(bus.LOOKUP_HIT), 128'(0));
    chk("rst_mem_data", bus.DATA_TO_MEM, 128'(0));
    chk("rst_mem_addr", 128'(bus.WR_ADDR_TO_MEM), 128'(0));
    // single line streamed straight through
    bus.WR_TO_MEM_READY = 1'b1;
    line(30'h100, 128'hA0, 4'b1010, 0, 4);
    chk("complete_pulse", 128'(bus.WR_COMPLETE), 128'(1));
    @(negedge clk);
    chk("complete_one_cycle", 128'(bus.WR_COMPLETE), 128'(0));
    wait_q(4);
    check_line(0, 30'h100, 128'hA0, 4'b1010);
    ack();
    repeat (2) @(negedge clk);
    chk("idle_mem_valid", 128'(bus.WR_TO_MEM_VALID), 128'(0));
    chk("idle_ready", 128'(bus.WR_TO_L2_READY), 128'(1));
    // three lines with the acknowledge withheld
    nc = n_complete;
    line(30'h140, 128'hB0, 4'b0110, 0, 4);
    line(30'h180, 128'hC0, 4'b0011, 0, 4);
    chk("full_ready", 128'(bus.WR_TO_L2_READY), 128'(0));
    up0 = n_up;
    bus.WR_TO_L2_VALID = 1'b1;
    bus.WR_ADDR_TO_L2 = 30'h1C0;
    bus.DATA_TO_L2 = 128'hD0;
    bus.WR_CONTROL_TO_L2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall_ready", 128'(bus.WR_TO_L2_READY), 128'(0));
    chk("stall_no_accept", 128'(n_up), 128'(up0));
    wait_q(8);
    ack();
    chk("after_ack_ready", 128'(bus.WR_TO_L2_READY), 128'(1));
    chk("after_ack_no_accept", 128'(n_up), 128'(up0));
    line(30'h1C0, 128'hD0, 4'b1001, 0, 4);
    wait_q(12);
    ack();
    wait_q(16);
    ack();
    check_line(4, 30'h140, 128'hB0, 4'b0110);
    check_line(8, 30'h180, 128'hC0, 4'b0011);
    check_line(12, 30'h1C0, 128'hD0, 4'b1001);
    chk("three_completes", 128'(n_complete), 128'(nc + 3));
    // downstream ready toggling
    bus.WR_TO_MEM_READY = 1'b0;
    line(30'h240, 128'hE0, 4'b1100, 0, 4);
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    for (int t = 0; t < 40 && q_data.size() < 20; t++) begin
      if (pv && !pr) chk("hold_data", bus.DATA_TO_MEM, pd);
      bus.WR_TO_MEM_READY = !bus.WR_TO_MEM_READY;
      pv = bus.WR_TO_MEM_VALID;
      pr = bus.WR_TO_MEM_READY;
      pd = bus.DATA_TO_MEM;
      @(negedge clk);
    end
    wait_q(20);
    repeat (3) @(negedge clk);
    chk("toggle_beats", 128'(q_data.size()), 128'(20));
    check_line(16, 30'h240, 128'hE0, 4'b1100);
    ack();
    // retirement of one line on the same edge another completes
    bus.WR_TO_MEM_READY = 1'b1;
    line(30'h280, 128'hF0, 4'b0101, 0, 4);
    wait_q(24);
    check_line(20, 30'h280, 128'hF0, 4'b0101);
    line(30'h2C0, 128'h1A0, 4'b1110, 0, 3);
    bus.WR_TO_L2_VALID = 1'b1;
    bus.DATA_TO_L2 = 128'h1A3;
    bus.WR_CONTROL_TO_L2 = 1'b1;
    bus.WR_COMPLETE_FROM_MEM = 1'b1;
    @(negedge clk);
    bus.WR_TO_L2_VALID = 1'b0;
    bus.WR_COMPLETE_FROM_MEM = 1'b0;
    chk("simul_complete", 128'(bus.WR_COMPLETE), 128'(1));
    chk("simul_ready", 128'(bus.WR_TO_L2_READY), 128'(1));
    line(30'h300, 128'h1C0, 4'b0001, 0, 4);
    chk("simul_then_full", 128'(bus.WR_TO_L2_READY), 128'(0));
    wait_q(28);
    check_line(24, 30'h2C0, 128'h1A0, 4'b1110);
    ack();
    wait_q(32);
    check_line(28, 30'h300, 128'h1C0, 4'b0001);
    ack();
    // reset mid-burst on both sides
    bus.WR_TO_MEM_READY = 1'b0;
    line(30'h340, 128'h200, 4'b1111, 0, 4);
    line(30'h380, 128'h210, 4'b0000, 0, 2);
    nc = n_complete;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 128'(bus.WR_TO_L2_READY), 128'(1));
    chk("midrst_mem_valid", 128'(bus.WR_TO_MEM_VALID), 128'(0));
    chk("midrst_complete", 128'(bus.WR_COMPLETE), 128'(0));
    chk("midrst_mem_data", bus.DATA_TO_MEM, 128'(0));
    chk("midrst_mem_addr", 128'(bus.WR_ADDR_TO_MEM), 128'(0));
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", 128'(n_complete), 128'(nc));
    chk("midrst_still_idle", 128'(bus.WR_TO_MEM_VALID), 128'(0));
    bus.WR_TO_MEM_READY = 1'b1;
    qs = q_data.size();
    line(30'h3C0, 128'h300, 4'b0110, 0, 4);
    chk("post_rst_complete", 128'(bus.WR_COMPLETE), 128'(1));
    wait_q(qs + 4);
    check_line(qs, 30'h3C0, 128'h300, 4'b0110);
    ack();
    // lookup hazard check against a buffered line
    bus.WR_TO_MEM_READY = 1'b0;
    line(30'h200, 128'h400, 4'b0101, 0, 4);
    bus.LOOKUP_ADDR = 30'h20C;
    #1;
    chk("lookup_same_line", 128'(bus.LOOKUP_HIT), 128'(EXP_HIT));
    bus.LOOKUP_ADDR = 30'h220;
    #1;
    chk("lookup_other_line", 128'(bus.LOOKUP_HIT), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
